// File: rtl/mem_stage_if.sv
// Data-SRAM request/response bundle between the memory stage (master) and the data SRAM (slave).
interface mem_stage_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one data-SRAM transaction per memory instruction, load align/extend.
// Optional macro MEM_LWLR_EN adds unaligned LWL/LWR word loads merged into es_rt_value.
//
// state  | meaning
// IDLE   | stage empty
// REQ    | data_sram.req asserted, waiting for addr_ok
// WAIT   | request accepted, waiting for data_ok
// DONE   | result held for the writeback stage
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [4:0]  es_dest,
  input  logic [31:0] es_alu_result,
  input  logic [31:0] es_mem_addr,
  input  logic        es_mem_re,
  input  logic        es_mem_we,
  input  logic [1:0]  es_mem_size,
  input  logic        es_mem_sext,
  input  logic [31:0] es_store_data,
`ifdef MEM_LWLR_EN
  input  logic [1:0]  es_lwlr,
  input  logic [31:0] es_rt_value,
`endif
  mem_stage_if.master data_sram,
  output logic        ms_to_ws_valid,
  input  logic        ws_allowin,
  output logic [31:0] ms_pc,
  output logic [4:0]  ms_dest,
  output logic [31:0] ms_result,
  output logic        ms_ex,
  output logic [31:0] ms_badvaddr,
  output logic        ms_fwd_stall
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] addr_q, addr_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] result_q, result_d;
  logic        ex_q, ex_d;
`ifdef MEM_LWLR_EN
  logic [1:0]  lwlr_q, lwlr_d;
  logic [31:0] rt_q, rt_d;
`endif

  logic        accept;
  logic        es_is_mem;
  logic        es_misalign;
  logic [31:0] ld_shift;
  logic [31:0] load_data;

  assign ms_allowin = (state_q == S_IDLE) | ((state_q == S_DONE) & ws_allowin);
  assign accept     = es_to_ms_valid & ms_allowin;
  assign es_is_mem  = es_mem_re | es_mem_we;

`ifdef MEM_LWLR_EN
  assign es_misalign = es_is_mem & ~|es_lwlr &
                       (((es_mem_size == 2'd1) & es_mem_addr[0]) |
                        ((es_mem_size == 2'd2) & |es_mem_addr[1:0]));
`else
  assign es_misalign = es_is_mem &
                       (((es_mem_size == 2'd1) & es_mem_addr[0]) |
                        ((es_mem_size == 2'd2) & |es_mem_addr[1:0]));
`endif

  always_comb begin
    ld_shift = data_sram.rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_data = {{24{sext_q & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    load_data = {{16{sext_q & ld_shift[15]}}, ld_shift[15:0]};
      default: load_data = ld_shift;
    endcase
`ifdef MEM_LWLR_EN
    // Little-endian LWL fills the upper bytes, LWR the lower bytes; the rest comes from rt.
    if (lwlr_q == 2'b01) begin
      case (addr_q[1:0])
        2'd0:    load_data = {data_sram.rdata[7:0],  rt_q[23:0]};
        2'd1:    load_data = {data_sram.rdata[15:0], rt_q[15:0]};
        2'd2:    load_data = {data_sram.rdata[23:0], rt_q[7:0]};
        default: load_data = data_sram.rdata;
      endcase
    end else if (lwlr_q == 2'b10) begin
      case (addr_q[1:0])
        2'd0:    load_data = data_sram.rdata;
        2'd1:    load_data = {rt_q[31:24], data_sram.rdata[31:8]};
        2'd2:    load_data = {rt_q[31:16], data_sram.rdata[31:16]};
        default: load_data = {rt_q[31:8],  data_sram.rdata[31:24]};
      endcase
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    dest_d   = dest_q;
    addr_d   = addr_q;
    re_d     = re_q;
    we_d     = we_q;
    size_d   = size_q;
    sext_d   = sext_q;
    sdata_d  = sdata_q;
    result_d = result_q;
    ex_d     = ex_q;
`ifdef MEM_LWLR_EN
    lwlr_d   = lwlr_q;
    rt_d     = rt_q;
`endif

    case (state_q)
      S_REQ:  if (data_sram.addr_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (data_sram.data_ok) begin
          state_d = S_DONE;
          if (re_q) result_d = load_data;
        end
      end
      S_DONE: if (ws_allowin) state_d = S_IDLE;
      default: ;
    endcase

    // Acceptance overrides the DONE->IDLE exit so back-to-back instructions flow.
    if (accept) begin
      pc_d     = es_pc;
      addr_d   = es_mem_addr;
      re_d     = es_mem_re;
      we_d     = es_mem_we;
      size_d   = es_mem_size;
      sext_d   = es_mem_sext;
      sdata_d  = es_store_data;
      ex_d     = es_misalign;
      dest_d   = es_misalign ? 5'd0 : es_dest;
      result_d = es_misalign ? 32'd0 : es_alu_result;
      state_d  = (es_is_mem & ~es_misalign) ? S_REQ : S_DONE;
`ifdef MEM_LWLR_EN
      lwlr_d   = es_lwlr;
      rt_d     = es_rt_value;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      dest_q   <= '0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      sdata_q  <= '0;
      result_q <= '0;
      ex_q     <= 1'b0;
`ifdef MEM_LWLR_EN
      lwlr_q   <= '0;
      rt_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      dest_q   <= dest_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      sdata_q  <= sdata_d;
      result_q <= result_d;
      ex_q     <= ex_d;
`ifdef MEM_LWLR_EN
      lwlr_q   <= lwlr_d;
      rt_q     <= rt_d;
`endif
    end
  end

  assign data_sram.req = (state_q == S_REQ);
  assign data_sram.wr  = we_q;
`ifdef MEM_LWLR_EN
  assign data_sram.size = (|lwlr_q) ? 2'd2 : size_q;
  assign data_sram.addr = (|lwlr_q) ? {addr_q[31:2], 2'b00} : addr_q;
`else
  assign data_sram.size = size_q;
  assign data_sram.addr = addr_q;
`endif

  always_comb begin
    data_sram.wstrb = 4'b0000;
    if (we_q) begin
      case (size_q)
        2'd0:    data_sram.wstrb = 4'b0001 << addr_q[1:0];
        2'd1:    data_sram.wstrb = 4'b0011 << addr_q[1:0];
        default: data_sram.wstrb = 4'b1111;
      endcase
    end
    case (size_q)
      2'd0:    data_sram.wdata = {4{sdata_q[7:0]}};
      2'd1:    data_sram.wdata = {2{sdata_q[15:0]}};
      default: data_sram.wdata = sdata_q;
    endcase
  end

  assign ms_to_ws_valid = (state_q == S_DONE);
  assign ms_pc          = pc_q;
  assign ms_dest        = dest_q;
  assign ms_result      = result_q;
  assign ms_ex          = ex_q;
  assign ms_badvaddr    = ex_q ? addr_q : 32'd0;
  assign ms_fwd_stall   = re_q & (|dest_q) & ((state_q == S_REQ) | (state_q == S_WAIT));

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: driver, SRAM responder, writeback monitor.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid, ms_allowin;
  logic [31:0] es_pc, es_alu_result, es_mem_addr, es_store_data;
  logic [4:0]  es_dest;
  logic        es_mem_re, es_mem_we, es_mem_sext;
  logic [1:0]  es_mem_size;
  logic        ms_to_ws_valid, ws_allowin;
  logic [31:0] ms_pc, ms_result, ms_badvaddr;
  logic [4:0]  ms_dest;
  logic        ms_ex, ms_fwd_stall;

  mem_stage_if data_sram();

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_dest(es_dest), .es_alu_result(es_alu_result),
    .es_mem_addr(es_mem_addr), .es_mem_re(es_mem_re), .es_mem_we(es_mem_we),
    .es_mem_size(es_mem_size), .es_mem_sext(es_mem_sext), .es_store_data(es_store_data),
    .data_sram(data_sram),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_ex(ms_ex), .ms_badvaddr(ms_badvaddr), .ms_fwd_stall(ms_fwd_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 alu, 1 load, 2 store
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] sdata;
    logic [31:0] rdata;
  } ins_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ex;
    logic [31:0] badvaddr;
    bit          chk_result;
    bit          fast;
    int          acc_cyc;
  } out_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
  } req_t;

  out_t exp_out[$];
  req_t exp_req[$];
  int   dok_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   reset_test = 0;
  bit   in_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference model: expected writeback and SRAM request derived from byte arithmetic.
  function automatic void model(input ins_t in, output out_t o, output req_t r, output bit hr);
    int     nb, off;
    bit     mem, mis;
    longint v;
    nb  = 1 << in.size;
    off = int'(in.addr % 4);
    mem = (in.kind != 0);
    mis = mem && ((in.addr % nb) != 0);
    o.pc         = in.pc;
    o.ex         = mis;
    o.badvaddr   = in.addr;
    o.dest       = mis ? 5'd0 : in.dest;
    o.fast       = !mem || mis;
    o.chk_result = (in.kind != 2) || mis;
    o.acc_cyc    = 0;
    o.result     = 32'd0;
    if (!mis && in.kind == 0) o.result = in.alu;
    if (!mis && in.kind == 1) begin
      v = longint'(in.rdata >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
      if (in.sext && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      o.result = v[31:0];
    end
    r.wr    = (in.kind == 2);
    r.size  = in.size;
    r.addr  = in.addr;
    r.stall = (in.kind == 1) && (in.dest != 0);
    r.rdata = in.rdata;
    r.wstrb = 4'b0000;
    r.wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (in.kind == 2 && i >= off && i < off + nb) r.wstrb[i] = 1'b1;
      r.wdata[8*i +: 8] = in.sdata[8*(i % nb) +: 8];
    end
    hr = mem && !mis;
  endfunction

  function automatic ins_t mk(input int kind, input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] alu, input logic [31:0] addr, input logic [1:0] size,
                              input logic sext, input logic [31:0] sdata, input logic [31:0] rdata);
    ins_t t;
    t.kind = kind; t.pc = pc; t.dest = dest; t.alu = alu; t.addr = addr;
    t.size = size; t.sext = sext; t.sdata = sdata; t.rdata = rdata;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int   nb;
    t.kind  = int'($urandom_range(0, 2));
    t.pc    = $urandom;
    t.dest  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.alu   = $urandom;
    t.size  = 2'($urandom_range(0, 2));
    t.sext  = 1'($urandom_range(0, 1));
    t.sdata = $urandom;
    t.rdata = $urandom;
    nb      = 1 << t.size;
    t.addr  = $urandom;
    if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~32'(nb - 1);
    return t;
  endfunction

  task automatic drive_idle();
    es_to_ms_valid = 1'b0;
    es_pc = $urandom; es_dest = 5'($urandom); es_alu_result = $urandom;
    es_mem_addr = $urandom; es_mem_re = 1'($urandom); es_mem_we = 1'($urandom);
    es_mem_size = 2'($urandom); es_mem_sext = 1'($urandom); es_store_data = $urandom;
  endtask

  // Entered and left at 2 time units after a rising edge.
  task automatic issue(input ins_t in, input bit push_out);
    out_t o;
    req_t r;
    bit   hr, acc;
    int   waitc;
    model(in, o, r, hr);
    if (hr) exp_req.push_back(r);
    es_to_ms_valid = 1'b1;
    es_pc = in.pc; es_dest = in.dest; es_alu_result = in.alu; es_mem_addr = in.addr;
    es_mem_re = (in.kind == 1); es_mem_we = (in.kind == 2);
    es_mem_size = in.size; es_mem_sext = in.sext; es_store_data = in.sdata;
    waitc = 0;
    forever begin
      #6;
      acc = ms_allowin;
      @(posedge clk);
      #2;
      if (acc) break;
      waitc++;
      if (waitc > 300) abort("accept_timeout");
    end
    o.acc_cyc = cyc;
    if (push_out) exp_out.push_back(o);
    drive_idle();
  endtask

  task automatic drain();
    int waitc = 0;
    while (exp_out.size() != 0) begin
      @(posedge clk);
      waitc++;
      if (waitc > 500) abort("drain_timeout");
    end
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},   32'(ms_to_ws_valid), 32'd0);
    chk({tag, "_allowin"}, 32'(ms_allowin), 32'd1);
    chk({tag, "_req"},     32'(data_sram.req), 32'd0);
    chk({tag, "_stall"},   32'(ms_fwd_stall), 32'd0);
    chk({tag, "_result"},  ms_result, 32'd0);
    chk({tag, "_pc"},      ms_pc, 32'd0);
    chk({tag, "_dest"},    32'(ms_dest), 32'd0);
    chk({tag, "_ex"},      32'(ms_ex), 32'd0);
    chk({tag, "_wstrb"},   32'(data_sram.wstrb), 32'd0);
    chk({tag, "_wr"},      32'(data_sram.wr), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Writeback consumer: random backpressure, bursts of up to three stalled cycles.
  initial begin
    int hold_cnt = 0;
    ws_allowin = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_cnt > 0) begin
        ws_allowin = 1'b0;
        hold_cnt--;
      end else if ($urandom_range(0, 5) == 0) begin
        ws_allowin = 1'b0;
        hold_cnt = int'($urandom_range(0, 2));
      end else begin
        ws_allowin = 1'b1;
      end
    end
  end

  // SRAM responder: checks each request, returns addr_ok/data_ok after random delays.
  initial begin
    int   ph = 0;
    int   cnt = 0;
    req_t cur;
    data_sram.addr_ok = 1'b0;
    data_sram.data_ok = 1'b0;
    data_sram.rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      data_sram.addr_ok = 1'b0;
      data_sram.data_ok = 1'b0;
      data_sram.rdata   = $urandom;
      if (!reset) begin
        ph = 0;
        in_wait = 0;
      end else if (ph == 2) begin
        chk("req_low_in_wait", 32'(data_sram.req), 32'd0);
        chk("stall_in_wait", 32'(ms_fwd_stall), 32'(cur.stall));
        if (reset_test) in_wait = 1;
        else if (cnt == 0) begin
          data_sram.data_ok = 1'b1;
          data_sram.rdata   = cur.rdata;
          dok_q.push_back(cyc);
          ph = 0;
        end else cnt--;
      end else begin
        if (ph == 0 && data_sram.req) begin
          if (exp_req.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: req=1 addr=0x%08h, required no request", data_sram.addr);
            cur.wr = data_sram.wr; cur.size = data_sram.size; cur.addr = data_sram.addr;
            cur.wstrb = data_sram.wstrb; cur.wdata = data_sram.wdata;
            cur.stall = ms_fwd_stall; cur.rdata = 32'd0;
          end else cur = exp_req.pop_front();
          cnt = int'($urandom_range(0, 2));
          ph = 1;
        end
        if (ph == 1) begin
          chk("req_held", 32'(data_sram.req), 32'd1);
          chk("req_wr", 32'(data_sram.wr), 32'(cur.wr));
          chk("req_size", 32'(data_sram.size), 32'(cur.size));
          chk("req_addr", data_sram.addr, cur.addr);
          chk("req_wstrb", 32'(data_sram.wstrb), 32'(cur.wstrb));
          if (cur.wr) chk("req_wdata", data_sram.wdata, cur.wdata);
          chk("stall_in_req", 32'(ms_fwd_stall), 32'(cur.stall));
          if (cnt == 0) begin
            data_sram.addr_ok = 1'b1;
            ph = 2;
            cnt = int'($urandom_range(0, 2));
          end else cnt--;
        end else begin
          chk("stall_idle", 32'(ms_fwd_stall), 32'd0);
          // Stray data_ok outside WAIT must be ignored by the stage.
          if (!reset_test && $urandom_range(0, 4) == 0) data_sram.data_ok = 1'b1;
        end
      end
    end
  end

  // Writeback monitor: compares the held result against the scoreboard head.
  initial begin
    bit   seen = 0;
    out_t o;
    forever begin
      @(negedge clk);
      if (reset && ms_to_ws_valid) begin
        if (exp_out.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: ms_to_ws_valid=1 pc=0x%08h, required no result", ms_pc);
        end else begin
          o = exp_out[0];
          if (!seen) begin
            seen = 1;
            if (o.fast) chk("valid_latency", 32'(cyc), 32'(o.acc_cyc));
            else if (dok_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL done_before_data_ok: valid at cycle %0d, required data_ok first", cyc);
            end else chk("done_after_data_ok", 32'(cyc), 32'(dok_q.pop_front() + 1));
          end
          chk("ms_pc", ms_pc, o.pc);
          chk("ms_dest", 32'(ms_dest), 32'(o.dest));
          chk("ms_ex", 32'(ms_ex), 32'(o.ex));
          if (o.chk_result) chk("ms_result", ms_result, o.result);
          if (o.ex) chk("ms_badvaddr", ms_badvaddr, o.badvaddr);
          chk("ms_allowin_done", 32'(ms_allowin), 32'(ws_allowin));
          if (ws_allowin) begin
            void'(exp_out.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    abort("global_watchdog");
  end

  initial begin
    int waitc;
    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #3;
    chk_reset_state("reset");
    reset = 1'b1;
    @(posedge clk);
    #2;

    issue(mk(0, 32'h0000_0100, 5'd3, 32'h1234_5678, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0), 1);
    issue(mk(1, 32'h0000_0104, 5'd7, 32'h0, 32'h0000_1003, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC), 1);
    issue(mk(2, 32'h0000_0108, 5'd0, 32'h0, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0), 1);
    issue(mk(1, 32'h0000_010C, 5'd9, 32'h0, 32'h0000_3001, 2'd2, 1'b0, 32'h0, 32'h0), 1);
    issue(mk(1, 32'h0000_0110, 5'd4, 32'h0, 32'h0000_4002, 2'd1, 1'b0, 32'h0, 32'h8001_7FFF), 1);
    issue(mk(2, 32'h0000_0114, 5'd0, 32'h0, 32'h0000_5005, 2'd1, 1'b0, 32'h0000_1234, 32'h0), 1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #2;
        end
      end
      issue(rand_ins(), 1);
    end
    drain();

    // Abandon a load sitting in WAIT via reset.
    reset_test = 1;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    issue(mk(1, 32'h0000_0200, 5'd6, 32'h0, 32'h0000_6000, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF), 0);
    waitc = 0;
    while (!in_wait) begin
      @(posedge clk);
      #3;
      waitc++;
      if (waitc > 50) abort("reach_wait_timeout");
    end
    reset = 1'b0;
    @(negedge clk);
    chk("mid_wait_stall", 32'(ms_fwd_stall), 32'd1);
    @(posedge clk);
    #3;
    chk_reset_state("mid_reset");
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    issue(mk(0, 32'h0000_0300, 5'd12, 32'hCAFE_F00D, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0), 1);
    drain();
    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
